// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared defaults, write-request type and packed-port helper for reg_file_mp
package rf_pkg;

   localparam int RF_DW  = 32;
   localparam int RF_AW  = 5;
   localparam int RF_NRD = 2;

   typedef struct packed {
      logic              en;
      logic [RF_AW-1:0]  addr;
      logic [RF_DW-1:0]  data;
   } wr_req_t;

   function automatic int rf_slice(input int idx, input int width);
      return idx * width;
   endfunction

endpackage

// File: rtl/rf_wr_stage.sv
// rtl/rf_wr_stage.sv - pause-gated write staging register, one per write port
module rf_wr_stage
   import rf_pkg::*;
#(
   parameter int DW = RF_DW,
   parameter int AW = RF_AW
) (
   input  logic          clock,
   input  logic          rst_n,
   input  logic          i_pause,
   input  logic          i_wren,
   input  logic [AW-1:0] i_wraddr,
   input  logic [DW-1:0] i_wdata,
   output logic          o_wren,
   output logic [AW-1:0] o_wraddr,
   output logic [DW-1:0] o_wdata
);

   logic          r_wren;
   logic [AW-1:0] r_wraddr;
   logic [DW-1:0] r_wdata;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_wren   <= 1'b0;
         r_wraddr <= '0;
         r_wdata  <= '0;
      end else if (!i_pause) begin
         r_wren   <= i_wren;
         r_wraddr <= i_wraddr;
         r_wdata  <= i_wdata;
      end
   end

   assign o_wren   = r_wren;
   assign o_wraddr = r_wraddr;
   assign o_wdata  = r_wdata;

endmodule

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-read, dual-staged-write register file with bypass
// Optional load-use scoreboard enabled by defining RF_SCOREBOARD_EN.
module reg_file_mp
   import rf_pkg::*;
#(
   parameter int DW       = RF_DW,
   parameter int AW       = RF_AW,
   parameter int NRD      = RF_NRD,
   parameter int ZERO_REG = 1
) (
   input  logic              clock,
   input  logic              rst_n,
   input  logic              pause,
   input  logic              rd_clk_cls,
   input  logic              wren_a,
   input  logic [AW-1:0]     wraddr_a,
   input  logic [DW-1:0]     wdata_a,
   input  logic              wren_b,
   input  logic [AW-1:0]     wraddr_b,
   input  logic [DW-1:0]     wdata_b,
   input  logic [NRD*AW-1:0] rdaddr,
`ifdef RF_SCOREBOARD_EN
   input  logic              sb_set,
   input  logic [AW-1:0]     sb_addr,
   output logic [NRD-1:0]    busy,
`endif
   output logic [NRD*DW-1:0] qdata
);

   localparam int DEPTH = 2 ** AW;

   logic          w_wren_a, w_wren_b;
   logic [AW-1:0] w_wraddr_a, w_wraddr_b;
   logic [DW-1:0] w_wdata_a, w_wdata_b;

   logic [DW-1:0] r_bank   [DEPTH];
   logic [AW-1:0] r_rdaddr [NRD];

   rf_wr_stage #(.DW(DW), .AW(AW)) u_stage_a (
      .clock(clock), .rst_n(rst_n), .i_pause(pause),
      .i_wren(wren_a), .i_wraddr(wraddr_a), .i_wdata(wdata_a),
      .o_wren(w_wren_a), .o_wraddr(w_wraddr_a), .o_wdata(w_wdata_a)
   );

   rf_wr_stage #(.DW(DW), .AW(AW)) u_stage_b (
      .clock(clock), .rst_n(rst_n), .i_pause(pause),
      .i_wren(wren_b), .i_wraddr(wraddr_b), .i_wdata(wdata_b),
      .o_wren(w_wren_b), .o_wraddr(w_wraddr_b), .o_wdata(w_wdata_b)
   );

   // Port B is assigned last so it wins a same-address commit.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) r_bank[k] <= '0;
      end else begin
         if (w_wren_a && !((ZERO_REG != 0) && (w_wraddr_a == '0)))
            r_bank[w_wraddr_a] <= w_wdata_a;
         if (w_wren_b && !((ZERO_REG != 0) && (w_wraddr_b == '0)))
            r_bank[w_wraddr_b] <= w_wdata_b;
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NRD; k++) r_rdaddr[k] <= '0;
      end else if (!pause && !rd_clk_cls) begin
         for (int k = 0; k < NRD; k++) r_rdaddr[k] <= rdaddr[k*AW +: AW];
      end
   end

   for (genvar g = 0; g < NRD; g++) begin : g_rd
      logic [DW-1:0] w_q;
      always_comb begin
         w_q = r_bank[r_rdaddr[g]];
         if ((ZERO_REG != 0) && (r_rdaddr[g] == '0))
            w_q = '0;
         else if (w_wren_b && (w_wraddr_b == r_rdaddr[g]))
            w_q = w_wdata_b;
         else if (w_wren_a && (w_wraddr_a == r_rdaddr[g]))
            w_q = w_wdata_a;
      end
      assign qdata[rf_slice(g, DW) +: DW] = w_q;
   end

`ifdef RF_SCOREBOARD_EN
   logic [DEPTH-1:0] r_sbv;

   // Set is applied after the writeback clear so a coincident set wins.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_sbv <= '0;
      end else begin
         if (w_wren_b) r_sbv[w_wraddr_b] <= 1'b0;
         if (!pause && sb_set) r_sbv[sb_addr] <= 1'b1;
         if (ZERO_REG != 0) r_sbv[0] <= 1'b0;
      end
   end

   for (genvar g = 0; g < NRD; g++) begin : g_busy
      assign busy[g] = r_sbv[r_rdaddr[g]] & ~(w_wren_b & (w_wraddr_b == r_rdaddr[g]));
   end
`endif

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - directed self-checking bench for reg_file_mp
module tb_reg_file_mp;

   logic        clock = 1'b0;
   logic        rst_n;
   logic        pause, rd_clk_cls;
   logic        wren_a, wren_b;
   logic [4:0]  wraddr_a, wraddr_b;
   logic [31:0] wdata_a, wdata_b;
   logic [9:0]  rdaddr;
   logic [63:0] qdata;
`ifdef RF_SCOREBOARD_EN
   logic        sb_set;
   logic [4:0]  sb_addr;
   logic [1:0]  busy;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   reg_file_mp dut (
      .clock(clock), .rst_n(rst_n), .pause(pause), .rd_clk_cls(rd_clk_cls),
      .wren_a(wren_a), .wraddr_a(wraddr_a), .wdata_a(wdata_a),
      .wren_b(wren_b), .wraddr_b(wraddr_b), .wdata_b(wdata_b),
      .rdaddr(rdaddr),
`ifdef RF_SCOREBOARD_EN
      .sb_set(sb_set), .sb_addr(sb_addr), .busy(busy),
`endif
      .qdata(qdata)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clock);
   endtask

   initial begin
      rst_n = 1'b1;
      pause = 1'b0; rd_clk_cls = 1'b0;
      wren_a = 1'b0; wraddr_a = '0; wdata_a = '0;
      wren_b = 1'b0; wraddr_b = '0; wdata_b = '0;
      rdaddr = {5'd3, 5'd0};
`ifdef RF_SCOREBOARD_EN
      sb_set = 1'b0; sb_addr = '0;
`endif
      #1 rst_n = 1'b0;
      tick(); tick();
      chk("rst_q0", qdata[31:0], 32'h0);
      chk("rst_q1", qdata[63:32], 32'h0);
`ifdef RF_SCOREBOARD_EN
      chk("rst_busy", {30'd0, busy}, 32'h0);
`endif
      rst_n = 1'b1;
      tick();
      chk("post_rst_q0", qdata[31:0], 32'h0);
      chk("post_rst_q1_r3", qdata[63:32], 32'h0);

      // port A write of r7: bypass then bank
      wren_a = 1'b1; wraddr_a = 5'd7; wdata_a = 32'h1234_5678;
      rdaddr = {5'd3, 5'd7};
      tick();
      chk("a_bypass_r7", qdata[31:0], 32'h1234_5678);
      wren_a = 1'b0;
      tick();
      chk("a_bank_r7", qdata[31:0], 32'h1234_5678);

      // collision on r9, B wins
      wren_a = 1'b1; wraddr_a = 5'd9; wdata_a = 32'hAAAA_AAAA;
      wren_b = 1'b1; wraddr_b = 5'd9; wdata_b = 32'h5555_5555;
      rdaddr = {5'd7, 5'd9};
      tick();
      chk("coll_bypass_r9", qdata[31:0], 32'h5555_5555);
      chk("coll_r7_port1", qdata[63:32], 32'h1234_5678);
      wren_a = 1'b0; wren_b = 1'b0;
      tick();
      chk("coll_bank_r9", qdata[31:0], 32'h5555_5555);

      // zero register
      wren_a = 1'b1; wraddr_a = 5'd0; wdata_a = 32'hFFFF_FFFF;
      rdaddr = {5'd9, 5'd0};
      tick();
      chk("zero_bypass", qdata[31:0], 32'h0);
      wren_a = 1'b0;
      tick();
      chk("zero_bank", qdata[31:0], 32'h0);

      // held read address
      wren_a = 1'b1; wraddr_a = 5'd4; wdata_a = 32'h4444_4444;
      wren_b = 1'b1; wraddr_b = 5'd5; wdata_b = 32'h5555_0005;
      rdaddr = {5'd9, 5'd4};
      tick();
      chk("r4_bypass", qdata[31:0], 32'h4444_4444);
      wren_a = 1'b0; wren_b = 1'b0;
      tick();
      rd_clk_cls = 1'b1; rdaddr = {5'd9, 5'd5};
      tick();
      chk("held_r4", qdata[31:0], 32'h4444_4444);
      rd_clk_cls = 1'b0;
      tick();
      chk("release_r5", qdata[31:0], 32'h5555_0005);

      // pause blocks staging and address capture
      pause = 1'b1;
      wren_a = 1'b1; wraddr_a = 5'd12; wdata_a = 32'hDEAD_BEEF;
      rdaddr = {5'd9, 5'd12};
      tick();
      chk("pause_addr_held", qdata[31:0], 32'h5555_0005);
      pause = 1'b0; wren_a = 1'b0;
      tick();
      chk("pause_r12_bypass", qdata[31:0], 32'h0);
      tick();
      chk("pause_r12_bank", qdata[31:0], 32'h0);

      // reset with a pending write to r13
      wren_a = 1'b1; wraddr_a = 5'd13; wdata_a = 32'h1313_1313;
      rdaddr = {5'd7, 5'd13};
      tick();
      chk("r13_pending", qdata[31:0], 32'h1313_1313);
      wren_a = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("midrst_q0", qdata[31:0], 32'h0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("midrst_r13", qdata[31:0], 32'h0);
      chk("midrst_r7", qdata[63:32], 32'h0);

`ifdef RF_SCOREBOARD_EN
      sb_set = 1'b1; sb_addr = 5'd5;
      rdaddr = {5'd6, 5'd5};
      tick();
      chk("sb_busy_r5", {31'd0, busy[0]}, 32'd1);
      chk("sb_idle_r6", {31'd0, busy[1]}, 32'd0);
      sb_set = 1'b0;
      wren_b = 1'b1; wraddr_b = 5'd5; wdata_b = 32'h0000_0077;
      tick();
      chk("sb_bypass_clear", {31'd0, busy[0]}, 32'd0);
      chk("sb_bypass_data", qdata[31:0], 32'h0000_0077);
      wren_b = 1'b0;
      sb_set = 1'b1; sb_addr = 5'd5;
      tick();
      chk("sb_set_wins", {31'd0, busy[0]}, 32'd1);
      sb_set = 1'b0; sb_addr = 5'd0;
      rdaddr = {5'd6, 5'd0};
      sb_set = 1'b1;
      tick();
      sb_set = 1'b0;
      chk("sb_zero_never", {31'd0, busy[0]}, 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
